adder_tree_arbiter: RTL and testbench



---
 rtl/adder_tree_arbiter.sv | 103 ++++++++++
 tb/tb_adder_tree_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_tree_arbiter.sv
// Round-robin front end that shares one pipelined 8-operand adder tree between
// NUM_REQ requesters, tagging each issued bundle so its sum returns with its ID.
module adder_tree_arbiter #(
  parameter int ADDER_WIDTH = 64,
  parameter int NUM_REQ     = 4,
  parameter int TREE_LAT    = 2,
  parameter int ID_W        = $clog2(NUM_REQ)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             en,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ*8*ADDER_WIDTH-1:0] req_data,
  output logic                             tree_vld,
  output logic [8*ADDER_WIDTH-1:0]         tree_op,
  input  logic [ADDER_WIDTH+2:0]           tree_sum,
  output logic                             rsp_valid,
  output logic [ID_W-1:0]                  rsp_id,
  output logic [ADDER_WIDTH+2:0]           rsp_sum,
  output logic                             idle
);

  localparam int BW = 8 * ADDER_WIDTH;

  logic [ID_W-1:0]                ptr;
  logic [ID_W-1:0]                cand_idx;
  logic [ID_W-1:0]                grant_idx;
  logic                           grant_found;
  logic                           xfer;
  logic [BW-1:0]                  sel_bundle;
  logic [ID_W-1:0]                tree_id;
  logic [TREE_LAT-1:0]            tag_vld;
  logic [TREE_LAT-1:0][ID_W-1:0]  tag_id;

  // First valid requester at or after ptr, wrapping cyclically.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_idx    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_idx = (int'(ptr) + i >= NUM_REQ) ? ID_W'(int'(ptr) + i - NUM_REQ)
                                            : ID_W'(int'(ptr) + i);
      if (!grant_found && req_valid[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  // Handshake: a bundle moves when req_valid[r] & req_ready[r] in the same cycle.
  // req_ready is combinational, at most one-hot, and zero while en=0 or rst_n=0;
  // the requester holds valid/data stable until that cycle.
  always_comb begin
    req_ready = '0;
    if (rst_n && en && grant_found) req_ready[grant_idx] = 1'b1;
  end

  assign xfer = |(req_valid & req_ready);

  always_comb begin
    sel_bundle = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (grant_idx == ID_W'(r)) sel_bundle = req_data[r*BW +: BW];
    end
  end

  // tree_id rides beside tree_vld; tag_vld/tag_id then follow the tree latency.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr       <= '0;
      tree_vld  <= 1'b0;
      tree_op   <= '0;
      tree_id   <= '0;
      tag_vld   <= '0;
      tag_id    <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
    end else begin
      tree_vld <= xfer;
      if (xfer) begin
        ptr     <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
        tree_op <= sel_bundle;
        tree_id <= grant_idx;
      end
      tag_vld[0] <= tree_vld;
      tag_id[0]  <= tree_id;
      for (int i = 1; i < TREE_LAT; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_id[i]  <= tag_id[i-1];
      end
      rsp_valid <= tag_vld[TREE_LAT-1];
      if (tag_vld[TREE_LAT-1]) begin
        rsp_id  <= tag_id[TREE_LAT-1];
        rsp_sum <= tree_sum;
      end
    end
  end

  assign idle = ~(|tag_vld) & ~tree_vld & ~rsp_valid & ~xfer;

endmodule

// File: tb/tb_adder_tree_arbiter.sv
// Scoreboard bench for adder_tree_arbiter: a behavioural round-robin model predicts
// grants and tagged sums; a separate monitor matches every rsp_valid pulse.
module tb_adder_tree_arbiter;

  localparam int W     = 64;
  localparam int N     = 4;
  localparam int L     = 2;
  localparam int IDW   = 2;
  localparam int BW    = 8 * W;
  localparam int SW    = W + 3;
  localparam int EXP_W = 32 + IDW + SW;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n = 1'b0;
  logic            en = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*BW-1:0] req_data = '0;
  logic            tree_vld;
  logic [BW-1:0]   tree_op;
  logic [SW-1:0]   tree_sum;
  logic            rsp_valid;
  logic [IDW-1:0]  rsp_id;
  logic [SW-1:0]   rsp_sum;
  logic            idle;

  adder_tree_arbiter #(.ADDER_WIDTH(W), .NUM_REQ(N), .TREE_LAT(L), .ID_W(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .tree_vld(tree_vld), .tree_op(tree_op), .tree_sum(tree_sum),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .idle(idle)
  );

  function automatic logic [SW-1:0] sum8(input logic [BW-1:0] b);
    logic [SW-1:0] s;
    s = '0;
    for (int k = 0; k < 8; k++) s = s + {3'b000, b[k*W +: W]};
    return s;
  endfunction

  // shared adder tree: L-cycle pipeline computing the sum of whatever sits on tree_op
  logic [SW-1:0] tree_pipe [L];
  always @(posedge clk) begin
    tree_pipe[0] <= sum8(tree_op);
    for (int i = 1; i < L; i++) tree_pipe[i] <= tree_pipe[i-1];
  end
  assign tree_sum = tree_pipe[L-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  logic [EXP_W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h required %0h", name, cyc, act, exp);
    end
  endtask

  // requester / reference model state
  logic [BW-1:0] bundle [N];
  logic [N-1:0]  want = '0;
  logic          rst_v = 1'b0;
  logic          en_v = 1'b1;
  int            model_ptr = 0;
  int            last_due = -1;
  logic          prev_xfer = 1'b0;
  logic [BW-1:0] prev_bundle = '0;
  logic          after_rst = 1'b0;

  task automatic new_bundle(input int r);
    for (int k = 0; k < 8; k++) bundle[r][k*W +: W] = {$urandom, $urandom};
  endtask

  task automatic rearm_all();
    for (int r = 0; r < N; r++) begin
      if (!want[r]) begin
        new_bundle(r);
        want[r] = 1'b1;
      end
    end
  endtask

  // one clock cycle: drive after posedge, predict and check at negedge
  task automatic tick();
    logic [N-1:0] exp_ready;
    int g;
    logic xfer;
    @(posedge clk);
    #1;
    rst_n     = rst_v;
    en        = en_v;
    req_valid = want;
    for (int r = 0; r < N; r++) req_data[r*BW +: BW] = bundle[r];
    @(negedge clk);
    g = -1;
    if (rst_v && en_v) begin
      for (int i = 0; i < N; i++) begin
        if (g < 0 && want[(model_ptr + i) % N]) g = (model_ptr + i) % N;
      end
    end
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    xfer = (g >= 0);
    chk("req_ready", req_ready, exp_ready);
    chk("tree_vld", tree_vld, prev_xfer);
    if (prev_xfer) chk("tree_op", tree_op, prev_bundle);
    if (after_rst) begin
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_rsp_sum", rsp_sum, 0);
      chk("rst_tree_op", tree_op, 0);
    end
    chk("idle", idle, (last_due < cyc) && !xfer);
    if (!rst_v) begin
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
        if (int'(exp_q[i][EXP_W-1 -: 32]) > cyc) exp_q.delete(i);
      end
      model_ptr = 0;
      last_due  = -1;
      prev_xfer = 1'b0;
      after_rst = 1'b1;
    end else begin
      after_rst = 1'b0;
      prev_xfer = xfer;
      if (xfer) begin
        prev_bundle = bundle[g];
        exp_q.push_back({32'(cyc + L + 2), IDW'(g), sum8(bundle[g])});
        last_due  = cyc + L + 2;
        model_ptr = (g + 1) % N;
        want[g]   = 1'b0;
      end
    end
  endtask

  // monitor: every rsp_valid pulse must match the oldest expected response
  logic [EXP_W-1:0] mon_e;
  always @(negedge clk) begin
    while (exp_q.size() > 0 && int'(exp_q[0][EXP_W-1 -: 32]) < cyc) begin
      mon_e = exp_q.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL rsp_missing @cyc %0d: got no rsp_valid, required id %0d sum %0h at cyc %0d",
               cyc, mon_e[SW +: IDW], mon_e[SW-1:0], int'(mon_e[EXP_W-1 -: 32]));
    end
    if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rsp_unexpected @cyc %0d: got id %0d sum %0h, required no response",
                 cyc, rsp_id, rsp_sum);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_cycle", 512'(cyc), 512'(int'(mon_e[EXP_W-1 -: 32])));
        chk("rsp_id", rsp_id, mon_e[SW +: IDW]);
        chk("rsp_sum", rsp_sum, mon_e[SW-1:0]);
      end
    end
  end

  initial begin
    #400000;
    n_cmp++;
    n_bad++;
    $display("FAIL watchdog: got no end of stimulus, required finish before %0t", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    for (int r = 0; r < N; r++) bundle[r] = '0;
    rst_v = 1'b0;
    repeat (3) tick();
    rst_v = 1'b1;

    // single request from requester 2, all operands 1
    for (int k = 0; k < 8; k++) bundle[2][k*W +: W] = 64'd1;
    want = 4'b0100;
    tick();
    repeat (6) tick();

    // fairness from a fresh pointer
    rst_v = 1'b0;
    tick();
    rst_v = 1'b1;
    repeat (8) begin
      rearm_all();
      tick();
    end
    want = '0;
    repeat (6) tick();

    // full-width operands from requester 1
    for (int k = 0; k < 8; k++) bundle[1][k*W +: W] = {W{1'b1}};
    want = 4'b0010;
    tick();
    repeat (6) tick();

    // enable gating with work in flight
    repeat (3) begin
      rearm_all();
      tick();
    end
    en_v = 1'b0;
    rearm_all();
    repeat (6) tick();
    en_v = 1'b1;
    repeat (4) begin
      rearm_all();
      tick();
    end
    want = '0;
    repeat (6) tick();

    // reset while two bundles are in flight
    repeat (2) begin
      rearm_all();
      tick();
    end
    want  = '0;
    rst_v = 1'b0;
    tick();
    rst_v = 1'b1;
    repeat (2) begin
      rearm_all();
      tick();
    end
    want = '0;
    repeat (6) tick();

    // pointer skip: ptr lands on 3, only requester 1 asks
    new_bundle(2);
    want = 4'b0100;
    tick();
    new_bundle(1);
    want = 4'b0010;
    tick();
    rearm_all();
    tick();
    want = '0;
    repeat (6) tick();

    // randomized traffic with occasional enable drops and resets
    for (int c = 0; c < 400; c++) begin
      en_v  = ($urandom_range(0, 9) != 0);
      rst_v = ($urandom_range(0, 149) != 0);
      for (int r = 0; r < N; r++) begin
        if (!want[r] && $urandom_range(0, 2) == 0) begin
          new_bundle(r);
          want[r] = 1'b1;
        end
      end
      tick();
    end
    rst_v = 1'b1;
    en_v  = 1'b1;

    for (int c = 0; c < 200 && (want != '0 || exp_q.size() > 0); c++) tick();
    repeat (2) tick();
    chk("drain_queue_empty", 512'(exp_q.size()), 512'(0));
    chk("drain_requests_done", want, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
